// File: rtl/pc_sequencer_pkg.sv
// Shared types for the program-counter sequencer: jump-command encoding,
// sequencer state and a small alignment helper.
package pc_sequencer_pkg;

    // Jump command applied when advance is asserted
    typedef enum logic [1:0] {
        JMP_REL = 2'b00,
        JMP_ABS = 2'b01,
        JMP_INC = 2'b10,
        JMP_RET = 2'b11
    } jump_e;

    // Sequencer state; ST_TRAP is only reachable when misalignment trapping is built in
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_TRAP = 1'b1
    } state_e;

    // Word stride used by the increment command
    localparam int unsigned PC_STEP = 4;

    // A PC is misaligned when either of its two low bits is set
    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return low_bits != 2'b00;
    endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// Interrupt return-address stack. Holds up to STACK_DEPTH program counters;
// push while full and pop while empty are ignored. Only the occupancy count
// is reset, so a reset discards every entry.
module pc_ret_stack #(
    parameter int unsigned ADDR_W      = 23,
    parameter int unsigned STACK_DEPTH = 4,
    localparam int unsigned PTR_W      = $clog2(STACK_DEPTH),
    localparam int unsigned CNT_W      = $clog2(STACK_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [ADDR_W-1:0] data_i,
    output logic [ADDR_W-1:0] top_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [CNT_W-1:0]  count_o
);

    logic [ADDR_W-1:0] mem_q [STACK_DEPTH];
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  wr_idx;
    logic [PTR_W-1:0]  top_idx;
    logic              do_push;
    logic              do_pop;

    assign full_o  = (count_q == CNT_W'(STACK_DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    // When not full the low pointer bits of the count address the next free slot
    assign wr_idx  = count_q[PTR_W-1:0];
    assign top_idx = count_q[PTR_W-1:0] - PTR_W'(1);
    assign top_o   = mem_q[top_idx];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o && !push_i;

    // Occupancy next-state
    always_comb begin
        count_d = count_q;
        if (do_push) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Occupancy register, cleared by reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Entry storage; contents are don't-care after reset so it is not reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_idx] <= data_i;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with relative/absolute/increment/return jumps and
// nested interrupt entry backed by a return-address stack.
// Build option: define PC_SEQUENCER_MISALIGN_TRAP_EN to redirect any misaligned
// next PC to TRAP_VEC and park in a TRAP state until reset. Without it the
// misaligned PC is loaded as computed and only pc_misaligned flags it.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned        ADDR_W      = 23,
    parameter int unsigned        STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0]  RESET_VEC   = '0,
    parameter logic [ADDR_W-1:0]  TRAP_VEC    = ADDR_W'('h10),
    localparam int unsigned       CNT_W       = $clog2(STACK_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              advance,
    input  logic [1:0]        jump,
    input  logic [ADDR_W-1:0] imm,
    input  logic              irq_req,
    input  logic [ADDR_W-1:0] irq_vec,
    output logic [ADDR_W-1:0] pc,
    output logic              irq_ack,
    output logic [CNT_W-1:0]  depth,
    output logic              pc_misaligned,
    output logic              ret_underflow,
    output logic              trapped
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              irq_ack_q, irq_ack_d;
    logic              ret_underflow_q, ret_underflow_d;

    logic              stk_push;
    logic              stk_pop;
    logic [ADDR_W-1:0] stk_top;
    logic              stk_full;
    logic              stk_empty;
    logic [CNT_W-1:0]  stk_count;

    pc_ret_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clk     (clk),
        .reset   (reset),
        .push_i  (stk_push),
        .pop_i   (stk_pop),
        .data_i  (pc_q),
        .top_o   (stk_top),
        .full_o  (stk_full),
        .empty_o (stk_empty),
        .count_o (stk_count)
    );

    // Decode the accepted event for this cycle into next PC, stack ops and flags
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        irq_ack_d       = 1'b0;
        ret_underflow_d = ret_underflow_q;
        stk_push        = 1'b0;
        stk_pop         = 1'b0;

        if (state_q == ST_RUN) begin
            if (irq_req && !stk_full) begin
                // Interrupt wins over a simultaneous advance; the command is dropped
                stk_push  = 1'b1;
                pc_d      = irq_vec;
                irq_ack_d = 1'b1;
            end else if (advance) begin
                unique case (jump_e'(jump))
                    JMP_REL: pc_d = pc_q + imm;
                    JMP_ABS: pc_d = imm;
                    JMP_INC: pc_d = pc_q + ADDR_W'(PC_STEP);
                    JMP_RET: begin
                        if (!stk_empty) begin
                            stk_pop = 1'b1;
                            pc_d    = stk_top;
                        end else begin
                            pc_d            = RESET_VEC;
                            ret_underflow_d = 1'b1;
                        end
                    end
                    default: pc_d = pc_q;
                endcase
            end

`ifdef PC_SEQUENCER_MISALIGN_TRAP_EN
            // A misaligned target aborts the event: no stack change, no acknowledge
            if (is_misaligned(pc_d[1:0])) begin
                pc_d      = TRAP_VEC;
                state_d   = ST_TRAP;
                irq_ack_d = 1'b0;
                stk_push  = 1'b0;
                stk_pop   = 1'b0;
            end
`endif
        end
    end

    // State and registered outputs; reset overrides every event
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q         <= ST_RUN;
            pc_q            <= RESET_VEC;
            irq_ack_q       <= 1'b0;
            ret_underflow_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            irq_ack_q       <= irq_ack_d;
            ret_underflow_q <= ret_underflow_d;
        end
    end

    assign pc            = pc_q;
    assign irq_ack       = irq_ack_q;
    assign depth         = stk_count;
    assign ret_underflow = ret_underflow_q;
    assign pc_misaligned = is_misaligned(pc_q[1:0]);

`ifdef PC_SEQUENCER_MISALIGN_TRAP_EN
    assign trapped = (state_q == ST_TRAP);
`else
    assign trapped = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (default parameters).
module tb_pc_sequencer;

    localparam logic [1:0] J_REL = 2'b00;
    localparam logic [1:0] J_ABS = 2'b01;
    localparam logic [1:0] J_INC = 2'b10;
    localparam logic [1:0] J_RET = 2'b11;

    logic        clk = 1'b0;
    logic        reset;
    logic        advance;
    logic [1:0]  jump;
    logic [22:0] imm;
    logic        irq_req;
    logic [22:0] irq_vec;
    logic [22:0] pc;
    logic        irq_ack;
    logic [2:0]  depth;
    logic        pc_misaligned;
    logic        ret_underflow;
    logic        trapped;

    int n_cmp  = 0;
    int n_fail = 0;

    pc_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .advance       (advance),
        .jump          (jump),
        .imm           (imm),
        .irq_req       (irq_req),
        .irq_vec       (irq_vec),
        .pc            (pc),
        .irq_ack       (irq_ack),
        .depth         (depth),
        .pc_misaligned (pc_misaligned),
        .ret_underflow (ret_underflow),
        .trapped       (trapped)
    );

    always #5 clk = ~clk;

    // Apply one cycle of inputs, then sample 1 ns after the edge
    task automatic cmd(input logic adv, input logic [1:0] j, input logic [22:0] im,
                       input logic irq, input logic [22:0] vec);
        advance = adv;
        jump    = j;
        imm     = im;
        irq_req = irq;
        irq_vec = vec;
        @(posedge clk);
        #1;
        advance = 1'b0;
        irq_req = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cmd(1'b0, J_INC, 23'h0, 1'b0, 23'h0);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        cmd(1'b1, J_INC, 23'h0, 1'b1, 23'h100);
        n_cmp++; if (pc !== 23'h0) begin n_fail++; $display("FAIL rst_pc got %h want 0", pc); end
        n_cmp++; if (depth !== 3'd0) begin n_fail++; $display("FAIL rst_depth got %0d want 0", depth); end
        n_cmp++; if (irq_ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack got %b want 0", irq_ack); end
        n_cmp++;
        if (ret_underflow !== 1'b0) begin
            n_fail++; $display("FAIL rst_uf got %b want 0", ret_underflow);
        end
        n_cmp++; if (trapped !== 1'b0) begin n_fail++; $display("FAIL rst_trap got %b want 0", trapped); end
        n_cmp++;
        if (pc_misaligned !== 1'b0) begin
            n_fail++; $display("FAIL rst_mis got %b want 0", pc_misaligned);
        end
        reset = 1'b1;
    endtask

    task automatic test_increment();
        logic [22:0] exp_pc [3];
        exp_pc[0] = 23'h4; exp_pc[1] = 23'h8; exp_pc[2] = 23'hC;
        for (int i = 0; i < 3; i++) begin
            cmd(1'b1, J_INC, 23'h0, 1'b0, 23'h0);
            n_cmp++;
            if (pc !== exp_pc[i]) begin
                n_fail++; $display("FAIL inc%0d pc got %h want %h", i, pc, exp_pc[i]);
            end
        end
        cmd(1'b0, J_INC, 23'h0, 1'b0, 23'h0);
        n_cmp++; if (pc !== 23'hC) begin n_fail++; $display("FAIL hold pc got %h want c", pc); end
    endtask

    task automatic test_wrap();
        do_reset();
        cmd(1'b1, J_ABS, 23'h7FFFFC, 1'b0, 23'h0);
        n_cmp++; if (pc !== 23'h7FFFFC) begin n_fail++; $display("FAIL abs pc got %h want 7ffffc", pc); end
        cmd(1'b1, J_INC, 23'h0, 1'b0, 23'h0);
        n_cmp++; if (pc !== 23'h0) begin n_fail++; $display("FAIL incwrap pc got %h want 0", pc); end
        cmd(1'b1, J_ABS, 23'h8, 1'b0, 23'h0);
        cmd(1'b1, J_REL, 23'h7FFFFC, 1'b0, 23'h0);
        n_cmp++; if (pc !== 23'h4) begin n_fail++; $display("FAIL relwrap pc got %h want 4", pc); end
    endtask

    task automatic test_nesting();
        logic [22:0] vecs [4];
        logic [22:0] rets [4];
        vecs[0] = 23'h100; vecs[1] = 23'h200; vecs[2] = 23'h300; vecs[3] = 23'h400;
        rets[0] = 23'h200; rets[1] = 23'h100; rets[2] = 23'h40;
        do_reset();
        cmd(1'b1, J_ABS, 23'h40, 1'b0, 23'h0);
        for (int i = 0; i < 4; i++) begin
            cmd(1'b0, J_INC, 23'h0, 1'b1, vecs[i]);
            n_cmp++;
            if (pc !== vecs[i] || irq_ack !== 1'b1 || depth !== 3'(i + 1)) begin
                n_fail++;
                $display("FAIL nest%0d pc/ack/depth got %h/%b/%0d want %h/1/%0d",
                         i, pc, irq_ack, depth, vecs[i], i + 1);
            end
        end
        // Stack full: request ignored, increment proceeds
        cmd(1'b1, J_INC, 23'h0, 1'b1, 23'h500);
        n_cmp++;
        if (pc !== 23'h404 || irq_ack !== 1'b0 || depth !== 3'd4) begin
            n_fail++;
            $display("FAIL full_irq pc/ack/depth got %h/%b/%0d want 404/0/4", pc, irq_ack, depth);
        end
        // Stack full: return executes alongside an interrupt request
        cmd(1'b1, J_RET, 23'h0, 1'b1, 23'h500);
        n_cmp++;
        if (pc !== 23'h300 || irq_ack !== 1'b0 || depth !== 3'd3) begin
            n_fail++;
            $display("FAIL full_ret pc/ack/depth got %h/%b/%0d want 300/0/3", pc, irq_ack, depth);
        end
        for (int i = 0; i < 3; i++) begin
            cmd(1'b1, J_RET, 23'h0, 1'b0, 23'h0);
            n_cmp++;
            if (pc !== rets[i] || depth !== 3'(2 - i)) begin
                n_fail++;
                $display("FAIL ret%0d pc/depth got %h/%0d want %h/%0d", i, pc, depth, rets[i], 2 - i);
            end
        end
        n_cmp++;
        if (ret_underflow !== 1'b0) begin
            n_fail++; $display("FAIL nest_uf got %b want 0", ret_underflow);
        end
    endtask

    task automatic test_irq_advance();
        do_reset();
        cmd(1'b1, J_ABS, 23'h8, 1'b0, 23'h0);
        cmd(1'b1, J_ABS, 23'h80, 1'b1, 23'h240);
        n_cmp++;
        if (pc !== 23'h240 || irq_ack !== 1'b1 || depth !== 3'd1) begin
            n_fail++;
            $display("FAIL irq_adv pc/ack/depth got %h/%b/%0d want 240/1/1", pc, irq_ack, depth);
        end
        cmd(1'b0, J_INC, 23'h0, 1'b0, 23'h0);
        n_cmp++; if (irq_ack !== 1'b0) begin n_fail++; $display("FAIL ack_pulse got %b want 0", irq_ack); end
        cmd(1'b1, J_RET, 23'h0, 1'b0, 23'h0);
        n_cmp++;
        if (pc !== 23'h8 || depth !== 3'd0) begin
            n_fail++; $display("FAIL irq_ret pc/depth got %h/%0d want 8/0", pc, depth);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        cmd(1'b1, J_ABS, 23'h20, 1'b0, 23'h0);
        cmd(1'b1, J_RET, 23'h0, 1'b0, 23'h0);
        n_cmp++;
        if (pc !== 23'h0 || ret_underflow !== 1'b1) begin
            n_fail++; $display("FAIL uf pc/uf got %h/%b want 0/1", pc, ret_underflow);
        end
        cmd(1'b1, J_INC, 23'h0, 1'b0, 23'h0);
        cmd(1'b1, J_INC, 23'h0, 1'b0, 23'h0);
        n_cmp++;
        if (pc !== 23'h8 || ret_underflow !== 1'b1) begin
            n_fail++; $display("FAIL uf_hold pc/uf got %h/%b want 8/1", pc, ret_underflow);
        end
        do_reset();
        n_cmp++;
        if (ret_underflow !== 1'b0) begin
            n_fail++; $display("FAIL uf_clear got %b want 0", ret_underflow);
        end
    endtask

    task automatic test_reset_mid_nest();
        do_reset();
        cmd(1'b0, J_INC, 23'h0, 1'b1, 23'h100);
        cmd(1'b0, J_INC, 23'h0, 1'b1, 23'h200);
        reset = 1'b0;
        cmd(1'b1, J_RET, 23'h0, 1'b1, 23'h300);
        reset = 1'b1;
        n_cmp++;
        if (depth !== 3'd0 || pc !== 23'h0 || irq_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_rst depth/pc/ack got %0d/%h/%b want 0/0/0", depth, pc, irq_ack);
        end
        cmd(1'b1, J_RET, 23'h0, 1'b0, 23'h0);
        n_cmp++;
        if (ret_underflow !== 1'b1 || pc !== 23'h0) begin
            n_fail++; $display("FAIL mid_rst_ret uf/pc got %b/%h want 1/0", ret_underflow, pc);
        end
    endtask

    task automatic test_misalign();
        do_reset();
        cmd(1'b1, J_ABS, 23'h6, 1'b0, 23'h0);
`ifdef PC_SEQUENCER_MISALIGN_TRAP_EN
        n_cmp++;
        if (pc !== 23'h10 || trapped !== 1'b1 || pc_misaligned !== 1'b0) begin
            n_fail++;
            $display("FAIL trap pc/trapped/mis got %h/%b/%b want 10/1/0", pc, trapped, pc_misaligned);
        end
        cmd(1'b1, J_INC, 23'h0, 1'b1, 23'h100);
        n_cmp++;
        if (pc !== 23'h10 || irq_ack !== 1'b0 || depth !== 3'd0 || trapped !== 1'b1) begin
            n_fail++;
            $display("FAIL trap_hold pc/ack/depth/trapped got %h/%b/%0d/%b want 10/0/0/1",
                     pc, irq_ack, depth, trapped);
        end
`else
        n_cmp++;
        if (pc !== 23'h6 || pc_misaligned !== 1'b1 || trapped !== 1'b0) begin
            n_fail++;
            $display("FAIL mis pc/mis/trapped got %h/%b/%b want 6/1/0", pc, pc_misaligned, trapped);
        end
        cmd(1'b1, J_INC, 23'h0, 1'b0, 23'h0);
        n_cmp++;
        if (pc !== 23'hA || pc_misaligned !== 1'b1) begin
            n_fail++; $display("FAIL mis_inc pc/mis got %h/%b want a/1", pc, pc_misaligned);
        end
        cmd(1'b1, J_REL, 23'h2, 1'b0, 23'h0);
        n_cmp++;
        if (pc !== 23'hC || pc_misaligned !== 1'b0) begin
            n_fail++; $display("FAIL mis_clr pc/mis got %h/%b want c/0", pc, pc_misaligned);
        end
`endif
    endtask

    initial begin
        reset   = 1'b0;
        advance = 1'b0;
        jump    = J_REL;
        imm     = '0;
        irq_req = 1'b0;
        irq_vec = '0;
        test_reset();
        test_increment();
        test_wrap();
        test_nesting();
        test_irq_advance();
        test_underflow();
        test_reset_mid_nest();
        test_misalign();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
